// File: rtl/jtkicker_psg_wrbuf.sv
// jtkicker_psg_wrbuf: CPU-to-PSG write buffer (latch + FIFO + strobe/ready handshake FSM).
// Define JTKICKER_PSG_DROPCNT_EN to build the saturating dropped-push counter on drops.
module jtkicker_psg_wrbuf #(
    parameter int AW  = 2,
    parameter int TMO = 15
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cpu_cen,
    input  logic       latch_we,
    input  logic       trig_cs,
    input  logic [7:0] cpu_dout,
    input  logic       psg_ready,
    output logic [7:0] psg_din,
    output logic       psg_cs_n,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic [7:0] drops
);
    localparam int D  = 1 << AW;
    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

    state_t          st_q, st_d;
    logic [7:0]      mem_q [D];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q;
    logic [7:0]      latch_q, din_q;
    logic            ovf_q;
    logic [TW-1:0]   tmo_q, tmo_d, tmo_inc;
    logic            wr_lat, push, pop, acc, drop;
    logic [7:0]      wdata;

    assign wr_lat   = cpu_cen & latch_we;
    assign push     = cpu_cen & trig_cs;
    assign wdata    = wr_lat ? cpu_dout : latch_q;
    assign full     = cnt_q == (AW+1)'(D);
    assign empty    = cnt_q == '0;
    assign pop      = (st_q == IDLE) && !empty && psg_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign acc      = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign psg_cs_n = st_q != STROBE;
    assign psg_din  = din_q;
    assign ovf      = ovf_q;

    always_comb begin
        st_d    = st_q;
        tmo_d   = tmo_q;
        tmo_inc = (tmo_q == TW'(TMO)) ? tmo_q : tmo_q + 1'b1;
        if (pop) begin
            st_d  = STROBE;
            tmo_d = '0;
        end else if (st_q == STROBE) begin
            tmo_d = tmo_inc;
            st_d  = (!psg_ready || tmo_inc == TW'(TMO)) ? WAIT : STROBE;
        end else if (st_q == WAIT && psg_ready) begin
            st_d  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_q    <= IDLE;
            tmo_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            latch_q <= '0;
            din_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            st_q  <= st_d;
            tmo_q <= tmo_d;
            cnt_q <= cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
            if (wr_lat) latch_q <= cpu_dout;
            if (acc) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q  <= rd_q + 1'b1;
                din_q <= mem_q[rd_q];
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[wr_q] <= wdata;
    end

`ifdef JTKICKER_PSG_DROPCNT_EN
    logic [7:0] drops_q;
    always_ff @(posedge clk) begin
        if (!rstn) drops_q <= '0;
        else if (drop && drops_q != 8'hFF) drops_q <= drops_q + 1'b1;
    end
    assign drops = drops_q;
`else
    assign drops = '0;
`endif
endmodule

// File: tb/tb_jtkicker_psg_wrbuf.sv
// tb_jtkicker_psg_wrbuf: directed table, hand-written handshake sequences and a
// randomized run against a queue-based model of the write buffer.
module tb_jtkicker_psg_wrbuf;
`ifdef JTKICKER_PSG_DROPCNT_EN
    localparam bit DC = 1'b1;
`else
    localparam bit DC = 1'b0;
`endif
    localparam int TMO = 15;

    logic       clk = 1'b0, rstn = 1'b0;
    logic       cpu_cen = 1'b0, latch_we = 1'b0, trig_cs = 1'b0;
    logic [7:0] cpu_dout = 8'h00;
    logic       man_ready = 1'b1, auto_ready = 1'b1, auto_m = 1'b0;
    logic       psg_ready;
    logic [7:0] psg_din, drops;
    logic       psg_cs_n, full, empty, ovf;
    logic [1:0] hold = 2'd0;

    assign psg_ready = auto_m ? auto_ready : man_ready;

    jtkicker_psg_wrbuf #(.AW(2), .TMO(TMO)) dut (
        .clk(clk), .rstn(rstn), .cpu_cen(cpu_cen), .latch_we(latch_we),
        .trig_cs(trig_cs), .cpu_dout(cpu_dout), .psg_ready(psg_ready),
        .psg_din(psg_din), .psg_cs_n(psg_cs_n), .full(full), .empty(empty),
        .ovf(ovf), .drops(drops)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Strobe capture and a simple PSG that pulls ready low for a random while
    logic [7:0] cap[$];
    int         lens[$];
    int         low_n = 0;
    always @(negedge clk) begin
        if (!psg_cs_n) begin
            if (low_n == 0) cap.push_back(psg_din);
            low_n <= low_n + 1;
        end else if (low_n != 0) begin
            lens.push_back(low_n);
            low_n <= 0;
        end
        if (!psg_cs_n && auto_ready) begin
            auto_ready <= 1'b0;
            hold       <= 2'($urandom_range(0, 3));
        end else if (!auto_ready) begin
            if (hold == 2'd0) auto_ready <= 1'b1;
            else hold <= hold - 2'd1;
        end
    end

    task automatic step(input logic c, input logic l, input logic t, input logic [7:0] d);
        cpu_cen = c; latch_we = l; trig_cs = t; cpu_dout = d;
        @(negedge clk);
        cpu_cen = 1'b0; latch_we = 1'b0; trig_cs = 1'b0;
    endtask

    task automatic do_reset();
        cpu_cen = 1'b0; latch_we = 1'b0; trig_cs = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_cap(input int n, input int lim);
        for (int k = 0; k < lim && cap.size() < n; k++) @(negedge clk);
    endtask

    typedef struct {
        logic       cen, lwe, trig;
        logic [7:0] dout;
        logic       full, empty, ovf;
        int         drops;
    } vec_t;

    vec_t       tv[8];
    logic [7:0] q[$];
    logic [7:0] lat, d;
    logic       m_ovf, c, l, t, prev_cs;
    int         m_drops, base, lb;

    initial begin
        tv[0] = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 0};
        tv[1] = '{1'b1, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 0};
        tv[3] = '{1'b1, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 1'b0, 0};
        tv[4] = '{1'b1, 1'b1, 1'b1, 8'h83, 1'b1, 1'b0, 1'b0, 0};
        tv[5] = '{1'b1, 1'b1, 1'b1, 8'h84, 1'b1, 1'b0, 1'b1, DC ? 1 : 0};
        tv[6] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, DC ? 2 : 0};
        tv[7] = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, DC ? 2 : 0};

        @(negedge clk);
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_drops", drops, 0);
        chk("rst_cs_n", psg_cs_n, 1);
        chk("rst_din", psg_din, 0);

        // Single write with a 3-cycle strobe ended by ready falling
        man_ready = 1'b1;
        base = cap.size(); lb = lens.size();
        step(1'b1, 1'b1, 1'b0, 8'h9F);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 10 && psg_cs_n; k++) @(negedge clk);
        chk("s34_strobe_seen", psg_cs_n, 0);
        repeat (2) @(negedge clk);
        man_ready = 1'b0;
        for (int k = 0; k < 20 && !psg_cs_n; k++) @(negedge clk);
        man_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("s34_n_strobes", lens.size() - lb, 1);
        if (lens.size() > lb) chk("s34_len", lens[lb], 3);
        if (cap.size() > base) chk("s34_din", cap[base], 8'h9F);
        chk("s34_empty", empty, 1);

        // Fill with ready low, overflow, then drain
        do_reset();
        man_ready = 1'b0;
        base = cap.size();
        for (int i = 0; i < 8; i++) begin
            step(tv[i].cen, tv[i].lwe, tv[i].trig, tv[i].dout);
            chk($sformatf("tv%0d_full", i), full, tv[i].full);
            chk($sformatf("tv%0d_empty", i), empty, tv[i].empty);
            chk($sformatf("tv%0d_ovf", i), ovf, tv[i].ovf);
            chk($sformatf("tv%0d_drops", i), drops, tv[i].drops);
        end
        chk("s35_no_strobe", cap.size() - base, 0);
        auto_m = 1'b1;
        wait_cap(base + 4, 200);
        repeat (20) @(negedge clk);
        chk("s36_count", cap.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (cap.size() > base + i) chk($sformatf("s36_byte%0d", i), cap[base+i], 8'h80 + i);
        chk("s36_empty", empty, 1);
        chk("s36_ovf_sticky", ovf, 1);

        // Latch write and trigger in the same cycle
        do_reset();
        base = cap.size();
        step(1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        wait_cap(base + 1, 30);
        repeat (10) @(negedge clk);
        chk("s38_count", cap.size() - base, 1);
        if (cap.size() > base) chk("s38_byte", cap[base], 8'h5A);

        // Ready stuck high: timeout strobes
        do_reset();
        auto_m = 1'b0; man_ready = 1'b1;
        base = cap.size(); lb = lens.size();
        step(1'b1, 1'b1, 1'b1, 8'hA1);
        step(1'b1, 1'b1, 1'b1, 8'hA2);
        for (int k = 0; k < 100 && lens.size() < lb + 2; k++) @(negedge clk);
        chk("s37_n_strobes", lens.size() - lb, 2);
        if (lens.size() > lb + 1) begin
            chk("s37_len0", lens[lb], TMO);
            chk("s37_len1", lens[lb+1], TMO);
        end
        if (cap.size() > base + 1) begin
            chk("s37_byte0", cap[base], 8'hA1);
            chk("s37_byte1", cap[base+1], 8'hA2);
        end
        chk("s37_empty", empty, 1);

        // Reset in the middle of a strobe with three entries queued
        do_reset();
        step(1'b1, 1'b1, 1'b1, 8'hB0);
        step(1'b1, 1'b1, 1'b1, 8'hB1);
        step(1'b1, 1'b1, 1'b1, 8'hB2);
        step(1'b1, 1'b1, 1'b1, 8'hB3);
        chk("s39_in_strobe", psg_cs_n, 0);
        chk("s39_queued_empty", empty, 0);
        rstn = 1'b0;
        @(negedge clk);
        chk("s39_cs_n", psg_cs_n, 1);
        chk("s39_empty", empty, 1);
        rstn = 1'b1;
        base = cap.size();
        repeat (40) @(negedge clk);
        chk("s39_no_strobe", cap.size() - base, 0);

        // Randomized traffic against the queue model, then drain
        do_reset();
        auto_m = 1'b1;
        q.delete(); lat = 8'h00; m_ovf = 1'b0; m_drops = 0;
        for (int i = 0; i < 3060; i++) begin
            c = (i < 3000) && ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            t = $urandom_range(0, 1) == 1;
            cpu_cen = c; latch_we = l; trig_cs = t; cpu_dout = 8'($urandom);
            d = cpu_dout;
            prev_cs = psg_cs_n;
            @(negedge clk);
            if (prev_cs && !psg_cs_n) begin
                chk("rnd_pop_nonempty", q.size() != 0, 1);
                if (q.size() != 0) chk("rnd_pop_data", psg_din, q.pop_front());
            end
            if (c && t) begin
                if (q.size() < 4) q.push_back((c && l) ? d : lat);
                else begin
                    m_ovf = 1'b1;
                    if (DC && m_drops < 255) m_drops++;
                end
            end
            if (c && l) lat = d;
            chk("rnd_full", full, q.size() == 4);
            chk("rnd_empty", empty, q.size() == 0);
            chk("rnd_ovf", ovf, m_ovf);
            chk("rnd_drops", drops, m_drops);
        end
        cpu_cen = 1'b0; latch_we = 1'b0; trig_cs = 1'b0;
        chk("rnd_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
